// File: rtl/display_scan_sched.sv
// Time-multiplexed 7-segment scan scheduler with blanking on mode change.
// Optional SCAN_BRIGHT_EN adds a 3-bit per-slot brightness duty control.
module display_scan_sched #(
  parameter int DIGITS      = 8,
  parameter int SCAN_DIV    = 50000,
  parameter int BLANK_SCANS = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            mode,
  input  logic [4*DIGITS-1:0]   id_digits,
  input  logic [4*DIGITS-1:0]   clk_digits,
  input  logic [4*DIGITS-1:0]   mul_digits,
`ifdef SCAN_BRIGHT_EN
  input  logic [2:0]            bright,
`endif
  output logic [DIGITS-1:0]     dig_n,
  output logic [7:0]            seg_n,
  output logic                  frame_start
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int FW = $clog2(BLANK_SCANS + 1);

  typedef enum logic [1:0] {
    S_OFF,
    S_BLANK,
    S_SHOW
  } state_t;

  state_t            state, state_d;
  logic [CW-1:0]     cnt, cnt_d;
  logic [IW-1:0]     idx, idx_d;
  logic [FW-1:0]     frames, frames_d;
  logic [1:0]        mode_q;
  logic [DIGITS-1:0] dig_q, onehot_n;
  logic [7:0]        seg_q, seg_dec;
  logic              fs_q;
  logic              tick, wrap, change, load;
  logic [4*DIGITS-1:0] bus;
  logic [3:0]        nib;

  always_comb begin
    tick     = (cnt == CW'(SCAN_DIV - 1));
    wrap     = tick && (idx == IW'(DIGITS - 1));
    change   = (mode != mode_q);
    state_d  = state;
    cnt_d    = tick ? '0 : cnt + 1'b1;
    idx_d    = idx;
    frames_d = frames;
    load     = 1'b0;
    if (tick)
      idx_d = wrap ? '0 : idx + 1'b1;
    unique case (state)
      S_OFF: begin
        cnt_d    = '0;
        idx_d    = '0;
        frames_d = '0;
      end
      S_BLANK: begin
        if (wrap) begin
          if (frames == FW'(BLANK_SCANS - 1)) begin
            frames_d = '0;
            state_d  = (mode_q != 2'b00) ? S_SHOW : S_OFF;
            load     = (mode_q != 2'b00);
          end else begin
            frames_d = frames + 1'b1;
          end
        end
      end
      S_SHOW: load = tick;
      default: state_d = S_OFF;
    endcase
    // A mode change overrides any advance landing in the same cycle
    if (change) begin
      cnt_d    = '0;
      idx_d    = '0;
      frames_d = '0;
      load     = 1'b0;
      state_d  = (mode == 2'b00) ? S_OFF : S_BLANK;
    end
  end

  always_comb begin
    unique case (mode_q)
      2'b01:   bus = id_digits;
      2'b10:   bus = clk_digits;
      2'b11:   bus = mul_digits;
      default: bus = '0;
    endcase
    nib      = bus[4*idx_d +: 4];
    onehot_n = ~(DIGITS'(1) << idx_d);
  end

  always_comb begin
    unique case (nib)
      4'd0:    seg_dec = 8'hC0;
      4'd1:    seg_dec = 8'hF9;
      4'd2:    seg_dec = 8'hA4;
      4'd3:    seg_dec = 8'hB0;
      4'd4:    seg_dec = 8'h99;
      4'd5:    seg_dec = 8'h92;
      4'd6:    seg_dec = 8'h82;
      4'd7:    seg_dec = 8'hF8;
      4'd8:    seg_dec = 8'h80;
      4'd9:    seg_dec = 8'h90;
      4'd11:   seg_dec = 8'hBF;
      default: seg_dec = 8'hFF;
    endcase
  end

`ifdef SCAN_BRIGHT_EN
  logic [2:0]  bright_q;
  logic [31:0] thr;
  logic        lit;

  always_comb begin
    thr = ((32'(bright_q) + 32'd1) * 32'(SCAN_DIV)) >> 3;
    lit = (32'(cnt) < thr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      bright_q <= '0;
    else if (load)
      bright_q <= bright;
  end

  assign dig_n = dig_q | {DIGITS{~lit}};
`else
  assign dig_n = dig_q;
`endif

  assign seg_n       = seg_q;
  assign frame_start = fs_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_OFF;
      cnt    <= '0;
      idx    <= '0;
      frames <= '0;
      mode_q <= 2'b00;
      dig_q  <= '1;
      seg_q  <= 8'hFF;
      fs_q   <= 1'b0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      idx    <= idx_d;
      frames <= frames_d;
      mode_q <= mode;
      fs_q   <= 1'b0;
      if (state_d != S_SHOW) begin
        dig_q <= '1;
        seg_q <= 8'hFF;
      end else if (load) begin
        dig_q <= onehot_n;
        seg_q <= seg_dec;
        fs_q  <= (idx_d == '0);
      end
    end
  end

endmodule

// File: tb/tb_display_scan_sched.sv
// Scoreboard bench for display_scan_sched (DIGITS=4, SCAN_DIV=4,
// BLANK_SCANS=1): per-cycle expected outputs queued, then drained.
module tb_display_scan_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [15:0] id_digits = '0;
  logic [15:0] clk_digits = '0;
  logic [15:0] mul_digits = '0;
  logic [3:0]  dig_n;
  logic [7:0]  seg_n;
  logic        frame_start;
`ifdef SCAN_BRIGHT_EN
  logic [2:0]  bright = 3'd7;
`endif

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [3:0] dig;
    logic [7:0] seg;
    logic       fs;
  } exp_t;

  exp_t q[$];

  display_scan_sched #(
    .DIGITS(4),
    .SCAN_DIV(4),
    .BLANK_SCANS(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .mode(mode),
    .id_digits(id_digits),
    .clk_digits(clk_digits),
    .mul_digits(mul_digits),
`ifdef SCAN_BRIGHT_EN
    .bright(bright),
`endif
    .dig_n(dig_n),
    .seg_n(seg_n),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s t=%0t observed=%h expected=%h", tag, $time, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] d, input logic [7:0] s,
                      input logic f, input int n);
    exp_t e;
    e.dig = d;
    e.seg = s;
    e.fs  = f;
    repeat (n) q.push_back(e);
  endtask

  task automatic push_dark(input int n);
    push(4'hF, 8'hFF, 1'b0, n);
  endtask

  task automatic push_frame(input logic [7:0] s0, input logic [7:0] s1,
                            input logic [7:0] s2, input logic [7:0] s3);
    push(4'b1110, s0, 1'b1, 1);
    push(4'b1110, s0, 1'b0, 3);
    push(4'b1101, s1, 1'b0, 4);
    push(4'b1011, s2, 1'b0, 4);
    push(4'b0111, s3, 1'b0, 4);
  endtask

  task automatic drain(input string tag);
    exp_t e;
    while (q.size() > 0) begin
      @(negedge clk);
      e = q.pop_front();
      chk({tag, ".dig"}, {4'h0, dig_n}, {4'h0, e.dig});
      chk({tag, ".seg"}, seg_n, e.seg);
      chk({tag, ".fs"}, {7'h0, frame_start}, {7'h0, e.fs});
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst.dig", {4'h0, dig_n}, 8'h0F);
    chk("rst.seg", seg_n, 8'hFF);
    chk("rst.fs", {7'h0, frame_start}, 8'h00);
    rst_n = 1'b1;
    push_dark(40);
    drain("idle");

    id_digits = 16'h4321;
    mode = 2'b01;
    push_dark(16);
    push_frame(8'hF9, 8'hA4, 8'hB0, 8'h99);
    drain("id");

    // This cycle is a tick cycle: switch lands on the slot advance
    mul_digits = 16'h8765;
    mode = 2'b11;
    push_dark(16);
    push_frame(8'h92, 8'h82, 8'hF8, 8'h80);
    drain("mul");

    clk_digits = 16'hBA09;
    mode = 2'b10;
    push_dark(16);
    push_frame(8'h90, 8'hC0, 8'hFF, 8'hBF);
    push(4'b1110, 8'h90, 1'b1, 1);
    push(4'b1110, 8'h90, 1'b0, 1);
    drain("clk");

    mode = 2'b00;
    push_dark(8);
    drain("off");

    mode = 2'b01;
    push_dark(16);
    push(4'b1110, 8'hF9, 1'b1, 1);
    push(4'b1110, 8'hF9, 1'b0, 1);
    drain("pre_rst");

    #1 rst_n = 1'b0;
    #1;
    chk("arst.dig", {4'h0, dig_n}, 8'h0F);
    chk("arst.seg", seg_n, 8'hFF);
    chk("arst.fs", {7'h0, frame_start}, 8'h00);
    mode = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    push_dark(8);
    drain("post_rst");

    mode = 2'b01;
    push_dark(16);
    push_frame(8'hF9, 8'hA4, 8'hB0, 8'h99);
    drain("resume");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
